// File: rtl/control_word_sequencer_pkg.sv
// Shared definitions for the control-word sequencer: field offsets,
// state encoding and the default idle word.
package control_word_sequencer_pkg;

  localparam int CW_W = 42;
  localparam int OW_W = 41;

  localparam int OP_BIT      = 41;
  localparam int RF_OUTA_LSB = 38;
  localparam int RF_OUTB_LSB = 35;
  localparam int RF_FUN_LSB  = 33;
  localparam int RF_RSEL_LSB = 29;
  localparam int RF_TSEL_LSB = 25;
  localparam int ALU_FUN_LSB = 21;
  localparam int ARF_OC_LSB  = 19;
  localparam int ARF_OD_LSB  = 17;
  localparam int ARF_FUN_LSB = 15;
  localparam int ARF_REG_LSB = 11;
  localparam int IR_LH_BIT   = 10;
  localparam int IR_EN_BIT   = 9;
  localparam int IR_FUN_LSB  = 7;
  localparam int MEM_WR_BIT  = 6;
  localparam int MEM_CS_BIT  = 5;
  localparam int MUXA_LSB    = 3;
  localparam int MUXB_LSB    = 1;
  localparam int MUXC_BIT    = 0;

  localparam logic [CW_W-1:0] IDLE_WORD_DEF = 42'h020;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

endpackage

// File: rtl/control_word_sequencer_cw_store.sv
// Control-word store: DEPTH x 42 registers, sync write, async read.
// Ports: clk_i, we_i, waddr_i, wdata_i, raddr_i, rdata_o.
module control_word_sequencer_cw_store
  import control_word_sequencer_pkg::*;
#(
  parameter int AW    = 4,
  parameter int DEPTH = 16
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [CW_W-1:0] wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [CW_W-1:0] rdata_o
);

  logic [CW_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/control_word_sequencer.sv
// Sequencer issuing stored control words to ALU_System control inputs.
// Ports: Clock/Reset, store write port, start/step/stop, field outputs.
module control_word_sequencer
  import control_word_sequencer_pkg::*;
#(
  parameter int              AW        = 4,
  parameter int              DEPTH     = 16,
  parameter logic [CW_W-1:0] IDLE_WORD = IDLE_WORD_DEF
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [CW_W-1:0] wr_data,
  input  logic            start,
  input  logic            step,
  input  logic            stop,
  input  logic [AW-1:0]   end_addr,
  input  logic            loop_en,
  output logic            busy,
  output logic            done,
  output logic [AW-1:0]   pc,
  output logic [15:0]     issue_cnt,
  output logic [2:0]      RF_OutASel,
  output logic [2:0]      RF_OutBSel,
  output logic [1:0]      RF_FunSel,
  output logic [3:0]      RF_RSel,
  output logic [3:0]      RF_TSel,
  output logic [3:0]      ALU_FunSel,
  output logic [1:0]      ARF_OutCSel,
  output logic [1:0]      ARF_OutDSel,
  output logic [1:0]      ARF_FunSel,
  output logic [3:0]      ARF_RegSel,
  output logic            IR_LH,
  output logic            IR_Enable,
  output logic [1:0]      IR_Funsel,
  output logic            Mem_WR,
  output logic            Mem_CS,
  output logic [1:0]      MuxASel,
  output logic [1:0]      MuxBSel,
  output logic            MuxCSel
);

  localparam logic [OW_W-1:0] IDLE_OW = IDLE_WORD[OW_W-1:0];

  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [OW_W-1:0] ow_q, ow_d;
  logic [CW_W-1:0] rd_data;
  logic [OW_W-1:0] issue_word;
  logic [15:0]     cnt_inc;
  logic            store_we;

  assign store_we = wr_en && (state_q != S_RUN);

  control_word_sequencer_cw_store #(
    .AW   (AW),
    .DEPTH(DEPTH)
  ) u_store (
    .clk_i  (Clock),
    .we_i   (store_we),
    .waddr_i(wr_addr),
    .wdata_i(wr_data),
    .raddr_i(pc_q),
    .rdata_o(rd_data)
  );

  // Words with Operation clear are issued as bubbles.
  assign issue_word = rd_data[OP_BIT] ? rd_data[OW_W-1:0] : IDLE_OW;
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ow_d    = IDLE_OW;
    unique case (state_q)
      S_IDLE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (start) begin
          pc_d    = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else if (step) begin
          ow_d  = issue_word;
          pc_d  = pc_q + AW'(1);
          cnt_d = cnt_inc;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (start) begin
          pc_d  = '0;
          cnt_d = '0;
        end else begin
          ow_d  = issue_word;
          cnt_d = cnt_inc;
          if (pc_q == end_addr) begin
            if (loop_en) begin
              pc_d = '0;
            end else begin
              state_d = S_HALT;
            end
          end else begin
            pc_d = pc_q + AW'(1);
          end
        end
      end
      S_HALT: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (start) begin
          pc_d    = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      ow_q    <= IDLE_OW;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ow_q    <= ow_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_HALT);
  assign pc        = pc_q;
  assign issue_cnt = cnt_q;

  assign RF_OutASel  = ow_q[RF_OUTA_LSB +: 3];
  assign RF_OutBSel  = ow_q[RF_OUTB_LSB +: 3];
  assign RF_FunSel   = ow_q[RF_FUN_LSB +: 2];
  assign RF_RSel     = ow_q[RF_RSEL_LSB +: 4];
  assign RF_TSel     = ow_q[RF_TSEL_LSB +: 4];
  assign ALU_FunSel  = ow_q[ALU_FUN_LSB +: 4];
  assign ARF_OutCSel = ow_q[ARF_OC_LSB +: 2];
  assign ARF_OutDSel = ow_q[ARF_OD_LSB +: 2];
  assign ARF_FunSel  = ow_q[ARF_FUN_LSB +: 2];
  assign ARF_RegSel  = ow_q[ARF_REG_LSB +: 4];
  assign IR_LH       = ow_q[IR_LH_BIT];
  assign IR_Enable   = ow_q[IR_EN_BIT];
  assign IR_Funsel   = ow_q[IR_FUN_LSB +: 2];
  assign Mem_WR      = ow_q[MEM_WR_BIT];
  assign Mem_CS      = ow_q[MEM_CS_BIT];
  assign MuxASel     = ow_q[MUXA_LSB +: 2];
  assign MuxBSel     = ow_q[MUXB_LSB +: 2];
  assign MuxCSel     = ow_q[MUXC_BIT];

endmodule

// File: tb/tb_control_word_sequencer.sv
// Self-checking bench for control_word_sequencer with a word-level
// reference model of the program store and issue order.
module tb_control_word_sequencer;

  logic        Clock = 0;
  logic        Reset, wr_en, start, step, stop, loop_en;
  logic [3:0]  wr_addr, end_addr;
  logic [41:0] wr_data;
  logic        busy, done;
  logic [3:0]  pc;
  logic [15:0] issue_cnt;
  logic [2:0]  RF_OutASel, RF_OutBSel;
  logic [1:0]  RF_FunSel;
  logic [3:0]  RF_RSel, RF_TSel, ALU_FunSel;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
  logic [3:0]  ARF_RegSel;
  logic        IR_LH, IR_Enable;
  logic [1:0]  IR_Funsel;
  logic        Mem_WR, Mem_CS;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel;

  control_word_sequencer dut (
    .Clock(Clock), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .step(step), .stop(stop),
    .end_addr(end_addr), .loop_en(loop_en), .busy(busy), .done(done),
    .pc(pc), .issue_cnt(issue_cnt),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel),
    .RF_FunSel(RF_FunSel), .RF_RSel(RF_RSel), .RF_TSel(RF_TSel),
    .ALU_FunSel(ALU_FunSel), .ARF_OutCSel(ARF_OutCSel),
    .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel),
    .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH), .IR_Enable(IR_Enable),
    .IR_Funsel(IR_Funsel), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
    .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel)
  );

  always #5 Clock = ~Clock;

  localparam logic [40:0] IDLE41 = 41'h020;

  logic [41:0] model_mem [16];
  int passed = 0;
  int total  = 0;

  wire [40:0] outs = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RSel,
    RF_TSel, ALU_FunSel, ARF_OutCSel, ARF_OutDSel, ARF_FunSel,
    ARF_RegSel, IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
    MuxASel, MuxBSel, MuxCSel};

  function automatic logic [40:0] expect_out(input logic [41:0] w);
    return w[41] ? w[40:0] : IDLE41;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic write_word(input logic [3:0] a, input logic [41:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic load(input logic [3:0] a, input logic [41:0] d);
    write_word(a, d);
    model_mem[a] = d;
  endtask

  function automatic logic [41:0] rnd_word();
    return {$urandom(), $urandom()};
  endfunction

  task automatic do_reset();
    Reset = 1; tick(); Reset = 0;
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic pulse_stop();
    stop = 1; tick(); stop = 0;
  endtask

  initial begin
    logic [41:0] w;
    int e, n;
    logic lp;
    Reset = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    start = 0; step = 0; stop = 0; end_addr = 0; loop_en = 0;
    for (int i = 0; i < 16; i++) model_mem[i] = 'x;

    do_reset();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_pc", 64'(pc), 64'(0));
    chk("rst_cnt", 64'(issue_cnt), 64'(0));
    chk("rst_out", 64'(outs), 64'(IDLE41));

    for (int i = 0; i < 16; i++) begin
      w = rnd_word();
      if (i < 4) begin
        w[41] = 1'b1;
        w[24:21] = 4'(i + 1);
      end
      load(4'(i), w);
    end

    end_addr = 3; loop_en = 0;
    pulse_start();
    chk("start_busy", 64'(busy), 64'(1));
    chk("start_out", 64'(outs), 64'(IDLE41));
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("seq_alu", 64'(ALU_FunSel), 64'(k + 1));
      chk("seq_out", 64'(outs), 64'(expect_out(model_mem[k])));
    end
    chk("halt_done", 64'(done), 64'(1));
    chk("halt_cnt", 64'(issue_cnt), 64'(4));
    tick();
    chk("halt_out", 64'(outs), 64'(IDLE41));
    step = 1; tick(); step = 0;
    chk("halt_step_ign", 64'(outs), 64'(IDLE41));

    loop_en = 1;
    pulse_start();
    chk("loop_done_clr", 64'(done), 64'(0));
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("loop_alu", 64'(ALU_FunSel), 64'((k % 4) + 1));
      chk("loop_busy", 64'(busy), 64'(1));
    end
    pulse_stop();
    chk("stop_busy", 64'(busy), 64'(0));
    chk("stop_pc", 64'(pc), 64'(2));
    chk("stop_cnt", 64'(issue_cnt), 64'(10));
    chk("stop_out", 64'(outs), 64'(IDLE41));

    w = model_mem[1]; w[41] = 1'b0;
    load(4'd1, w);
    loop_en = 0;
    pulse_start();
    tick();
    chk("bub_w0", 64'(ALU_FunSel), 64'(1));
    tick();
    chk("bub_idle", 64'(outs), 64'(IDLE41));
    tick(); tick();
    chk("bub_cnt", 64'(issue_cnt), 64'(4));
    chk("bub_done", 64'(done), 64'(1));

    do_reset();
    for (int k = 0; k < 3; k++) begin
      step = 1; tick(); step = 0;
      chk("step_out", 64'(outs), 64'(expect_out(model_mem[k])));
      chk("step_pc", 64'(pc), 64'(k + 1));
      tick();
      chk("step_gap", 64'(outs), 64'(IDLE41));
    end

    end_addr = 15; loop_en = 1;
    pulse_start();
    tick();
    write_word(4'd2, 42'h3_0000_0000_01);
    pulse_stop();
    do_reset();
    step = 1; tick(); tick(); tick(); step = 0;
    chk("run_wr_ign", 64'(outs), 64'(expect_out(model_mem[2])));

    end_addr = 0; loop_en = 0;
    pulse_start();
    tick();
    chk("e0_done", 64'(done), 64'(1));
    chk("e0_cnt", 64'(issue_cnt), 64'(1));
    load(4'd2, 42'h2_A5A5_5A5A_C3);
    end_addr = 2;
    pulse_start();
    tick(); tick(); tick();
    chk("halt_wr", 64'(outs), 64'(expect_out(model_mem[2])));

    pulse_stop();
    start = 1; step = 1; tick(); start = 0; step = 0;
    chk("ss_busy", 64'(busy), 64'(1));
    chk("ss_pc", 64'(pc), 64'(0));
    chk("ss_out", 64'(outs), 64'(IDLE41));

    end_addr = 15; loop_en = 0;
    for (int k = 0; k < 5; k++) tick();
    chk("mid_pc", 64'(pc), 64'(5));
    do_reset();
    chk("mrst_pc", 64'(pc), 64'(0));
    chk("mrst_busy", 64'(busy), 64'(0));
    chk("mrst_cnt", 64'(issue_cnt), 64'(0));
    chk("mrst_out", 64'(outs), 64'(IDLE41));
    for (int k = 0; k < 6; k++) begin
      step = 1; tick();
      chk("mrst_store", 64'(outs), 64'(expect_out(model_mem[k])));
    end
    step = 0;

    for (int it = 0; it < 12; it++) begin
      pulse_stop();
      for (int a = 0; a < 16; a++) load(4'(a), rnd_word());
      e  = int'($urandom_range(0, 15));
      lp = 1'($urandom_range(0, 1));
      n  = int'($urandom_range(1, 24));
      end_addr = 4'(e); loop_en = lp;
      pulse_start();
      for (int j = 1; j <= n; j++) begin
        tick();
        if (lp) begin
          chk("rnd_out", 64'(outs), 64'(expect_out(model_mem[(j - 1) % (e + 1)])));
          chk("rnd_pc", 64'(pc), 64'(j % (e + 1)));
          chk("rnd_cnt", 64'(issue_cnt), 64'(j));
        end else begin
          chk("rnd_out", 64'(outs), 64'((j <= e + 1) ?
              expect_out(model_mem[j - 1]) : IDLE41));
          chk("rnd_pc", 64'(pc), 64'((j < e) ? j : e));
          chk("rnd_cnt", 64'(issue_cnt), 64'((j < e + 1) ? j : e + 1));
          chk("rnd_done", 64'(done), 64'(j >= e + 1));
        end
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
